// File: rtl/alu_core.sv
// alu_core: registered 8-bit ALU for the basic processor datapath.
// One-cycle latency; result, zero flag and shift-carry load on every edge.
module alu_core #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [W-1:0] InputA,
    input  logic [W-1:0] InputB,
    input  logic         SC_in,
    input  logic [3:0]   OP,
    output logic [W-1:0] Out,
    output logic         Zero,
    output logic         SC_out
);

    typedef enum logic [3:0] {
        OP_LSH = 4'b0000,
        OP_RSH = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_GEQ = 4'b1000,
        OP_EQ  = 4'b1001,
        OP_NEG = 4'b1010,
        OP_ADD = 4'b1011,
        OP_SUB = 4'b1100,
        OP_NEQ = 4'b1101
    } op_t;

    logic [W-1:0] res;
    logic         sc;
    logic [W:0]   sum;
    logic [W:0]   diff;
    logic [W-1:0] neg;
    logic         geq;
    logic         eq;

    // Extra MSB carries the carry-out for ADD and the borrow for SUB.
    assign sum  = {1'b0, InputA} + {1'b0, InputB};
    assign diff = {1'b0, InputA} - {1'b0, InputB};
    assign neg  = (~InputA) + W'(1);
    assign geq  = (InputA >= InputB);
    assign eq   = (InputA == InputB);

    always_comb begin
        res = '0;
        sc  = 1'b0;
        case (OP)
            OP_LSH: begin
                res = {InputA[W-2:0], SC_in};
                sc  = InputA[W-1];
            end
            OP_RSH: begin
                res = {1'b0, InputA[W-1:1]};
                sc  = InputA[0];
            end
            OP_AND: res = InputA & InputB;
            OP_OR:  res = InputA | InputB;
            OP_XOR: res = InputA ^ InputB;
            OP_GEQ: res = W'(geq);
            OP_EQ:  res = W'(eq);
            OP_NEG: res = neg;
            OP_ADD: begin
                res = sum[W-1:0];
                sc  = sum[W];
            end
            OP_SUB: begin
                res = diff[W-1:0];
                sc  = diff[W];
            end
            OP_NEQ: res = W'(!eq);
            default: begin
                res = '0;
                sc  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Out    <= '0;
            Zero   <= 1'b0;
            SC_out <= 1'b0;
        end else begin
            Out    <= res;
            Zero   <= (res == '0);
            SC_out <= sc;
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed vectors into a scoreboard queue,
// checked by an independent monitor one cycle later.
module tb_alu_core;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] InputA;
    logic [7:0] InputB;
    logic       SC_in;
    logic [3:0] OP;
    logic [7:0] Out;
    logic       Zero;
    logic       SC_out;

    alu_core #(.W(8)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .InputA (InputA),
        .InputB (InputB),
        .SC_in  (SC_in),
        .OP     (OP),
        .Out    (Out),
        .Zero   (Zero),
        .SC_out (SC_out)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sc;
        logic [3:0] op;
        logic [7:0] out;
        logic       z;
        logic       sco;
    } vec_t;

    typedef struct {
        int         id;
        logic [7:0] out;
        logic       z;
        logic       sco;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h want %0h", name, act, req);
    endtask

    task automatic apply(input int id, input vec_t v);
        exp_t e;
        InputA = v.a;
        InputB = v.b;
        SC_in  = v.sc;
        OP     = v.op;
        e.id   = id;
        e.out  = v.out;
        e.z    = v.z;
        e.sco  = v.sco;
        expq.push_back(e);
    endtask

    // Monitor: one result per rising edge, sampled 1ns after it.
    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check($sformatf("v%0d.out", e.id), Out, e.out);
            check($sformatf("v%0d.zero", e.id), {7'b0, Zero}, {7'b0, e.z});
            check($sformatf("v%0d.sc", e.id), {7'b0, SC_out}, {7'b0, e.sco});
        end
    end

    vec_t vecs[$];

    initial begin
        //          a      b      sc    op       out    z     sco
        vecs.push_back('{8'h01, 8'h01, 1'b0, 4'b1011, 8'h02, 1'b0, 1'b0});
        vecs.push_back('{8'h81, 8'h00, 1'b1, 4'b0000, 8'h03, 1'b0, 1'b1});
        vecs.push_back('{8'h81, 8'h00, 1'b1, 4'b0001, 8'h40, 1'b0, 1'b1});
        vecs.push_back('{8'h01, 8'h00, 1'b0, 4'b0000, 8'h02, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 8'h55, 1'b1, 4'b0001, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h01, 8'h01, 1'b0, 4'b0010, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 8'h00, 1'b0, 4'b0011, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{8'hF0, 8'h0F, 1'b0, 4'b0010, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'hA5, 8'hFF, 1'b1, 4'b0100, 8'h5A, 1'b0, 1'b0});
        vecs.push_back('{8'h03, 8'h04, 1'b0, 4'b1000, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h04, 8'h04, 1'b0, 4'b1000, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 8'h7F, 1'b0, 4'b1000, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{8'h02, 8'h02, 1'b0, 4'b1001, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{8'h02, 8'h03, 1'b0, 4'b1001, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h01, 8'h03, 1'b0, 4'b1101, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{8'h05, 8'h05, 1'b0, 4'b1101, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h01, 8'h33, 1'b0, 4'b1010, 8'hFF, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 8'h33, 1'b0, 4'b1010, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h80, 8'h00, 1'b0, 4'b1010, 8'h80, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 4'b1011, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h03, 8'h05, 1'b0, 4'b1100, 8'hFE, 1'b0, 1'b1});
        vecs.push_back('{8'h05, 8'h03, 1'b0, 4'b1100, 8'h02, 1'b0, 1'b0});
        vecs.push_back('{8'h07, 8'h00, 1'b0, 4'b1111, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 4'b0101, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 4'b1110, 8'h00, 1'b1, 1'b0});
    end

    initial begin
        vec_t fill;
        vec_t hold;
        int   budget;

        Reset  = 1'b1;
        InputA = '0;
        InputB = '0;
        SC_in  = 1'b0;
        OP     = '0;
        #1;
        check("reset.out", Out, 8'h00);
        check("reset.zero", {7'b0, Zero}, 8'h00);
        check("reset.sc", {7'b0, SC_out}, 8'h00);

        // Load 0xFF, then reset asynchronously mid-cycle.
        @(negedge Clk);
        Reset = 1'b0;
        fill = '{8'hFF, 8'h00, 1'b0, 4'b0011, 8'hFF, 1'b0, 1'b0};
        apply(100, fill);
        @(posedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        check("async.out", Out, 8'h00);
        check("async.zero", {7'b0, Zero}, 8'h00);
        check("async.sc", {7'b0, SC_out}, 8'h00);

        // Back-to-back vectors, one per cycle.
        @(negedge Clk);
        Reset = 1'b0;
        foreach (vecs[i]) begin
            apply(i, vecs[i]);
            @(negedge Clk);
        end

        // Outputs hold while inputs change between edges.
        hold = '{8'h10, 8'h20, 1'b0, 4'b1011, 8'h30, 1'b0, 1'b0};
        apply(200, hold);
        @(posedge Clk);
        #3;
        InputA = 8'hFF;
        InputB = 8'hFF;
        OP     = 4'b1011;
        #1;
        check("hold.out", Out, 8'h30);
        check("hold.sc", {7'b0, SC_out}, 8'h00);
        @(negedge Clk);
        check("hold2.out", Out, 8'h30);
        hold = '{8'hFF, 8'hFF, 1'b0, 4'b1011, 8'hFE, 1'b0, 1'b1};
        apply(201, hold);

        budget = 0;
        while (expq.size() > 0 && budget < 20) begin
            @(negedge Clk);
            budget++;
        end
        if (expq.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d pending want 0", expq.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- 8-bit registered arithmetic/logic unit for the basic processor datapath.
- Takes two operands from the register file, a 4-bit opcode from the control decoder, and a shift-carry input.
- Produces a result, a zero flag and a shift-carry output, all registered on the processor clock.
- Compare ops return a 0/1 result used for branch decisions.

Parameters:
- W, 8, operand/result width. All ops are defined generically; W=8 is the only width verified.

Ports:
- Clk     input   1   processor clock, rising-edge active
- Reset   input   1   asynchronous, active-high reset
- InputA  input   W   operand A
- InputB  input   W   operand B
- SC_in   input   1   shift-carry input (fill bit for LSH)
- OP      input   4   opcode
- Out     output  W   registered result
- Zero    output  1   registered flag, 1 when the result is all zeros
- SC_out  output  1   registered shift-carry/carry-out

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: while Reset=1, Out=0, Zero=0 and SC_out=0, independent of Clk. Reset deasserted mid-operation: the first rising Clk after release captures the current inputs normally.
- Structure:
  - A combinational result is computed from InputA, InputB, SC_in and OP.
  - Out, Zero and SC_out load on every rising Clk; there is no enable.
  - Latency is exactly 1 cycle: inputs applied before edge N appear at the outputs after edge N.
- Opcodes (unsigned arithmetic, results truncated to W bits):
  - 0000 LSH: res={A[W-2:0],SC_in}; sc=A[W-1]
  - 0001 RSH: res={1'b0,A[W-1:1]}; sc=A[0]
  - 0010 AND: res=A&B; sc=0
  - 0011 OR: res=A|B (bitwise); sc=0
  - 0100 XOR: res=A^B; sc=0
  - 1000 GEQ: res=(A>=B)?1:0, unsigned, zero-extended to W; sc=0
  - 1001 EQ: res=(A==B)?1:0; sc=0
  - 1010 NEG: res=~A+1 (two's complement, B ignored); sc=0. NEG of 0 gives 0; NEG of 8'h80 gives 8'h80.
  - 1011 ADD: res=A+B mod 2^W; sc=carry out of the MSB
  - 1100 SUB: res=A-B mod 2^W; sc=1 when A<B (borrow)
  - 1101 NEQ: res=(A!=B)?1:0; sc=0
  - All other opcodes (0101,0110,0111,1110,1111): res=0, sc=0. No error is flagged.
- Zero: registered (res==0), computed from the same cycle's res for every opcode, including compares and undefined opcodes.
- SC_in is used only by LSH and is ignored by all other opcodes.
- No internal state other than the three output registers. Outputs hold between edges even if inputs change.
- X/undefined inputs are not required to be handled.

Test Plan:
- Reset: assert Reset asynchronously mid-cycle with Out=8'hFF loaded -> Out=0, Zero=0, SC_out=0 immediately, before any Clk edge. Release Reset, A=1, B=1, OP=1011 -> after next edge Out=8'h02, Zero=0.
- Shifts:
  - A=8'h81, SC_in=1, OP=0000 -> Out=8'h03, SC_out=1.
  - A=8'h81, OP=0001 -> Out=8'h40, SC_out=1.
  - A=1, SC_in=0, OP=0000 -> Out=8'h02.
- Logic:
  - A=1, B=1, OP=0010 -> Out=1.
  - A=1, B=0, OP=0011 -> Out=1.
  - A=8'hF0, B=8'h0F, OP=0010 -> Out=0, Zero=1.
- Compares:
  - A=3, B=4, GEQ -> Out=0, Zero=1.
  - A=4, B=4, GEQ -> Out=1.
  - A=2, B=2, EQ -> Out=1.
  - A=1, B=3, NEQ -> Out=1.
  - A=5, B=5, NEQ -> Out=0, Zero=1.
- Arithmetic:
  - A=1, NEG -> Out=8'hFF.
  - A=0, NEG -> Out=0, Zero=1.
  - A=8'hFF, B=1, ADD -> Out=0, SC_out=1, Zero=1.
  - A=3, B=5, SUB -> Out=8'hFE, SC_out=1.
- Latency/undefined:
  - Change inputs between edges -> outputs stable until the next rising Clk.
  - OP=1111, A=7 -> Out=0, Zero=1.
  - Back-to-back different ops on consecutive cycles -> each result appears exactly one cycle later.
